// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: imem address/data, redirect request and the instruction stream to decode.
// The master modport is the fetch controller; the slave modport is the imem plus decode side.
interface imem_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_dout;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [31:0]           instr_pc;
    logic                  instr_ready;

    modport master (
        output imem_addr,
        input  imem_dout,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_addr,
        output imem_dout,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle synchronous imem; issue-to-valid latency is 2 cycles.
// Backpressure: instr_ready low holds the head; issue stops once buffered + in-flight words reach 2.
module imem_fetch_ctrl #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    imem_fetch_ctrl_if.master   fif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [31:0]           pc;
    } entry_t;

    logic [31:0]     fetch_pc_q,    fetch_pc_d;
    logic            inflight_q,    inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    entry_t [1:0]    fifo_q,        fifo_d;
    logic            rd_ptr_q,      rd_ptr_d;
    logic            wr_ptr_q,      wr_ptr_d;
    logic [1:0]      count_q,       count_d;

    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      occupancy;
    logic [31:0]     redirect_base;
    entry_t          head;

    always_comb begin
        fif.instr_valid = (count_q != 2'd0);
        pop             = fif.instr_valid & fif.instr_ready;
        push            = inflight_q & ~fif.redirect_valid;
        redirect_base   = fif.redirect_pc & ~32'd3;

        // Words already owed a slot (buffered + in flight) minus the one leaving now.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (occupancy < 3'd2);

        head         = fifo_q[rd_ptr_q];
        fif.instr    = fif.instr_valid ? head.instr : '0;
        fif.instr_pc = fif.instr_valid ? head.pc    : '0;

        fif.imem_addr = fif.redirect_valid ? redirect_base[ADDR_WIDTH+1:2]
                                           : fetch_pc_q[ADDR_WIDTH+1:2];
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        fifo_d        = fifo_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (fif.redirect_valid) begin
            // Flush everything; the response landing this cycle belongs to the old stream.
            count_d       = 2'd0;
            rd_ptr_d      = 1'b0;
            wr_ptr_d      = 1'b0;
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_base;
            fetch_pc_d    = redirect_base + 32'd4;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end else begin
                inflight_d = 1'b0;
            end

            if (push) begin
                fifo_d[wr_ptr_q] = '{instr: fif.imem_dout, pc: inflight_pc_q};
                wr_ptr_d         = ~wr_ptr_q;
            end

            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end

            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fifo_q        <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fifo_q        <= fifo_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a 1-cycle synchronous imem whose word encodes its address.
module tb_imem_fetch_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    imem_fetch_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();

    imem_fetch_ctrl #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // imem content: word at address a is 0xC0DE0000 | a
    always @(posedge clk) bus.imem_dout <= 32'hC0DE0000 | {23'd0, bus.imem_addr};

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return 32'hC0DE0000 | {23'd0, pc[10:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"},   {31'd0, bus.instr_valid}, 32'd1);
        chk({tag, "_pc"},    bus.instr_pc,             pc);
        chk({tag, "_instr"}, bus.instr,                exp_word(pc));
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_vld"},   {31'd0, bus.instr_valid}, 32'd0);
        chk({tag, "_instr"}, bus.instr,                32'd0);
        chk({tag, "_pc"},    bus.instr_pc,             32'd0);
        chk({tag, "_addr"},  {23'd0, bus.imem_addr},   32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst");

        // Reset release, streaming with ready high
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0);
        chk("t1_c0_vld", {31'd0, bus.instr_valid}, 32'd0);
        chk("t1_c0_addr", {23'd0, bus.imem_addr}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        chk("t1_c1_vld", {31'd0, bus.instr_valid}, 32'd0);
        adv();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            expect_instr($sformatf("t1_seq%0d", i), 32'(i * 4));
            adv();
        end

        // Stall on the second valid word for 5 cycles
        do_reset();
        repeat (2) begin drive(1'b1, 1'b0, 32'h0); adv(); end
        drive(1'b1, 1'b0, 32'h0);
        expect_instr("t2_first", 32'h0);
        adv();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            expect_instr($sformatf("t2_hold%0d", i), 32'h4);
            if (i > 0) chk($sformatf("t2_addr%0d", i), {23'd0, bus.imem_addr}, 32'd3);
            adv();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            expect_instr($sformatf("t2_resume%0d", i), 32'(4 + i * 4));
            adv();
        end

        // Redirect while the FIFO holds pc 8 and 12
        do_reset();
        repeat (2) begin drive(1'b1, 1'b0, 32'h0); adv(); end
        drive(1'b1, 1'b0, 32'h0); expect_instr("t3_p0", 32'h0); adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t3_p4", 32'h4); adv();
        drive(1'b0, 1'b0, 32'h0); expect_instr("t3_p8", 32'h8); adv();
        drive(1'b0, 1'b1, 32'h0000_0102);
        expect_instr("t3_full", 32'h8);
        chk("t3_raddr", {23'd0, bus.imem_addr}, 32'h40);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        chk("t3_bubble", {31'd0, bus.instr_valid}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t3_tgt0", 32'h100); adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t3_tgt1", 32'h104); adv();

        // Back-to-back redirects: last one wins
        drive(1'b1, 1'b1, 32'h40); adv();
        drive(1'b1, 1'b1, 32'h80);
        chk("t4_r1_vld", {31'd0, bus.instr_valid}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        chk("t4_r2_vld", {31'd0, bus.instr_valid}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t4_tgt0", 32'h80); adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t4_tgt1", 32'h84); adv();

        // imem address wrap at the top of the 512-word array
        drive(1'b1, 1'b1, 32'h0000_07FC);
        chk("t5_addr0", {23'd0, bus.imem_addr}, 32'h1FF);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        chk("t5_addr1", {23'd0, bus.imem_addr}, 32'h0);
        chk("t5_bubble", {31'd0, bus.instr_valid}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t5_w0", 32'h7FC); adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t5_w1", 32'h800); adv();

        // 32-bit PC wrap, low target bits ignored
        drive(1'b1, 1'b1, 32'hFFFF_FFFE); adv();
        drive(1'b1, 1'b0, 32'h0); adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t6_w0", 32'hFFFF_FFFC); adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t6_w1", 32'h0); adv();

        // Mid-stream async reset with the FIFO full
        repeat (3) begin drive(1'b0, 1'b0, 32'h0); adv(); end
        chk("t7_full_vld", {31'd0, bus.instr_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t7_rst");
        adv();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0);
        chk("t7_c0_vld", {31'd0, bus.instr_valid}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        chk("t7_c1_vld", {31'd0, bus.instr_valid}, 32'd0);
        adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t7_p0", 32'h0); adv();
        drive(1'b1, 1'b0, 32'h0); expect_instr("t7_p4", 32'h4); adv();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
